// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM states and lane extract/merge helpers for mem_access_unit
package mem_access_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_t;
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] offset,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = word >> {offset, 3'b000};
    return size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
           size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : word;
  endfunction
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] offset, input logic [1:0] size);
    logic [31:0] mask;
    mask = (size == SZ_BYTE ? 32'h0000_00FF : size == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF)
           << {offset, 3'b000};
    return (word & ~mask) | ((wdata << {offset, 3'b000}) & mask);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational lane extraction, store merge and alignment-error detection
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  chk_offset,
  input  logic [1:0]  chk_size,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged,
  output logic        align_err
);
  assign align_err = chk_size == 2'b11 || (chk_size == SZ_HALF && chk_offset[0]) ||
                     (chk_size == SZ_WORD && chk_offset != 2'b00);
  assign load_data = load_extract(word, offset, size, uns);
  assign merged    = store_merge(word, wdata, offset, size);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store front end over a word RAM (read-modify-write for sub-word stores).
// Optional range check enabled by defining MEM_ACCESS_BOUNDS_CHECK_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int SIZE       = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [31:0]           ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_write,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  state_t      state, next_state;
  logic [31:0] addr_q, store_q, rdata_q, load_data, merged;
  logic [1:0]  size_q;
  logic        uns_q, write_q, err_q, accept, align_err, oob, req_err;
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  assign oob = {2'b00, req_addr[31:2]} >= 32'(SIZE);
`else
  assign oob = 1'b0;
`endif
  assign req_err = align_err || oob;
  assign accept  = req_valid && req_ready;
  mem_lane_align u_align (
    .chk_offset(req_addr[1:0]),
    .chk_size  (req_size),
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .uns       (uns_q),
    .word      (ram_data_out),
    .wdata     (store_q),
    .load_data (load_data),
    .merged    (merged),
    .align_err (align_err)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_RESP: next_state = !accept ? S_IDLE : req_err ? S_RESP :
                                   (req_write && req_size == SZ_WORD) ? S_WR : S_RD;
      S_RD:    next_state = S_CAP;
      S_CAP:   next_state = write_q ? S_WR : S_RESP;
      S_WR:    next_state = S_RESP;
      default: next_state = S_IDLE;
    endcase
  end
  // store_q holds raw store data until CAP replaces it with the merged word
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      store_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      write_q <= req_write;
      err_q   <= req_err;
      store_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == S_CAP) begin
      if (write_q) store_q <= merged;
      else rdata_q <= load_data;
    end
  always_comb begin
    req_ready      = reset && (state == S_IDLE || state == S_RESP);
    ram_read_en    = state == S_RD;
    ram_write_en   = state == S_WR;
    ram_address    = (state == S_RD || state == S_WR) ? {addr_q[31:2], 2'b00} : '0;
    ram_data_write = state == S_WR ? store_q : '0;
    resp_valid     = state == S_RESP;
    resp_error     = state == S_RESP && err_q;
    resp_rdata     = state == S_RESP ? rdata_q : '0;
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a behavioural word RAM
module tb_mem_access_unit;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_error, ram_write_en, ram_read_en;
  logic [31:0] resp_rdata, ram_address, ram_data_write, ram_data_out = '0;
  logic [31:0] mem [32];
  logic [31:0] last_wdata = '0, last_raddr = '0;
  int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
  int          n_checks = 0, n_fail = 0;

  mem_access_unit #(.SIZE(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .ram_address(ram_address),
    .ram_data_write(ram_data_write), .ram_write_en(ram_write_en),
    .ram_read_en(ram_read_en), .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_read_en && ram_write_en) both_cnt++;
    if (ram_write_en) begin
      mem[ram_address[6:2]] <= ram_data_write;
      last_wdata = ram_data_write;
      wr_cnt++;
    end
    if (ram_read_en) begin
      ram_data_out <= mem[ram_address[6:2]];
      last_raddr = ram_address;
      rd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input int exp_edges,
                     input logic exp_err, input logic [31:0] exp_rdata, input int exp_rd,
                     input int exp_wr);
    int edges;
    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    edges = 1;
    while (!resp_valid && edges < 8) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(exp_edges));
    check({tag, " error"}, 32'(resp_error), 32'(exp_err));
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " reads"}, 32'(rd_cnt), 32'(exp_rd));
    check({tag, " writes"}, 32'(wr_cnt), 32'(exp_wr));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst strobes", {30'd0, ram_read_en, ram_write_en}, 32'd0);
    check("rst ram_address", ram_address, 32'd0);
    reset = 1'b1;
    #1;
    check("post-rst ready", 32'(req_ready), 32'd1);

    req("sw 0x14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h0000_000B, 2, 1'b0, 32'h0, 0, 1);
    req("lw 0x14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 3, 1'b0, 32'h0000_000B, 1, 0);
    req("sw init", 1'b1, 2'b10, 1'b0, 32'h14, 32'h80FF_7F01, 2, 1'b0, 32'h0, 0, 1);
    req("lb 0x17", 1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 3, 1'b0, 32'hFFFF_FF80, 1, 0);
    req("lbu 0x17", 1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 3, 1'b0, 32'h0000_0080, 1, 0);
    req("lh 0x14", 1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 3, 1'b0, 32'h0000_7F01, 1, 0);
    req("sh 0x16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_BEEF, 4, 1'b0, 32'h0, 1, 1);
    check("sh merged word", last_wdata, 32'hBEEF_7F01);
    req("lw after sh", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 3, 1'b0, 32'hBEEF_7F01, 1, 0);
    req("lhu 0x16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 3, 1'b0, 32'h0000_BEEF, 1, 0);
    req("lh 0x16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 3, 1'b0, 32'hFFFF_BEEF, 1, 0);
    req("sb 0x15", 1'b1, 2'b00, 1'b0, 32'h15, 32'h1234_5678, 4, 1'b0, 32'h0, 1, 1);
    check("sb merged word", last_wdata, 32'hBEEF_7801);
    req("lbu 0x15", 1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 3, 1'b0, 32'h0000_0078, 1, 0);
    req("lh 0x13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    req("sw 0x16", 1'b1, 2'b10, 1'b0, 32'h16, 32'hDEAD_BEEF, 1, 1'b1, 32'h0, 0, 0);
    req("size 11", 1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 1, 1'b1, 32'h0, 0, 0);
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    req("lw 0x80 oob", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 1, 1'b1, 32'h0, 0, 0);
`else
    req("lw 0x80 alias", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 3, 1'b0, 32'h0, 1, 0);
    check("lw 0x80 ram_address", last_raddr, 32'h80);
`endif

    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid-rst ready", 32'(req_ready), 32'd0);
    check("mid-rst resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid-rst no write", 32'(wr_cnt), 32'd0);
    check("mid-rst ready after", 32'(req_ready), 32'd1);
    req("lw after abort", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 3, 1'b0, 32'hBEEF_7801, 1, 0);
    check("strobe overlap", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
